// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO mult/div sequencer: core selects, read-mux
// selects and controller states.
package hilo_muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_sel_e;

  typedef enum logic [1:0] {
    RD_CP0 = 2'b00,
    RD_HI  = 2'b01,
    RD_LO  = 2'b10
  } rd_sel_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_WB   = 2'b10
  } state_e;

  // Illegal multi-strobe decodes resolve as div > divu > mult > multu.
  function automatic md_sel_e md_pick(input logic div, input logic divu, input logic mult);
    if (div)       return MD_DIV;
    else if (divu) return MD_DIVU;
    else if (mult) return MD_MULT;
    else           return MD_MULTU;
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Decode-strobe / HI-LO control bundle between the CPU decode stage (master)
// and the mult/div sequencer (slave).
interface hilo_muldiv_ctrl_if;
  logic       op_mult;
  logic       op_multu;
  logic       op_div;
  logic       op_divu;
  logic       op_mthi;
  logic       op_mtlo;
  logic       op_mfhi;
  logic       op_mflo;
  logic       divisor_zero;
  logic       md_start;
  logic [1:0] md_sel;
  logic       hi_wen;
  logic       lo_wen;
  logic       hilo_src;
  logic [1:0] rd_sel;
  logic       stall;
  logic       busy;
  logic       div_zero_err;

  modport master (
    output op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo, op_mfhi, op_mflo,
    output divisor_zero,
    input  md_start, md_sel, hi_wen, lo_wen, hilo_src, rd_sel, stall, busy, div_zero_err
  );

  modport slave (
    input  op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo, op_mfhi, op_mflo,
    input  divisor_zero,
    output md_start, md_sel, hi_wen, lo_wen, hilo_src, rd_sel, stall, busy, div_zero_err
  );
endinterface

// File: rtl/md_lat_counter.sv
// Loadable latency down-counter; saturates at 1 so a long RUN phase can never
// wrap and fire a spurious write-back.
module md_lat_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             is_one
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg > CNT_W'(1))) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign is_one = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer: accepts one mult/div at a time, times the core latency,
// issues the HI/LO write-back and stalls the CPU on HI/LO hazards.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 1,
  parameter int DIV_LAT = 34,
  parameter int CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  hilo_muldiv_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

  state_e           state_reg;
  md_sel_e          md_sel_reg;
  md_sel_e          md_sel_next;
  logic             md_start_reg;
  logic             wb_wen_reg;
  logic             div_zero_err_reg;
  logic             zero_reg;

  logic             any_md;
  logic             any_op;
  logic             is_div;
  logic             is_idle;
  logic             accept;
  logic             mt_ok;
  logic             cnt_dec;
  logic             cnt_is_one;
  logic [CNT_W-1:0] lat_load;

  assign any_md  = bus.op_mult | bus.op_multu | bus.op_div | bus.op_divu;
  assign any_op  = any_md | bus.op_mthi | bus.op_mtlo | bus.op_mfhi | bus.op_mflo;
  assign is_div  = bus.op_div | bus.op_divu;
  assign is_idle = (state_reg == S_IDLE);
  assign accept  = is_idle & any_md;

  assign md_sel_next = md_pick(bus.op_div, bus.op_divu, bus.op_mult);
  assign lat_load    = is_div ? DIV_CNT : MUL_CNT;
  assign cnt_dec     = (state_reg == S_RUN) & ~cnt_is_one;

  md_lat_counter #(
    .CNT_W (CNT_W)
  ) u_lat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (lat_load),
    .dec      (cnt_dec),
    .is_one   (cnt_is_one)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= S_IDLE;
      md_sel_reg       <= MD_MULT;
      md_start_reg     <= 1'b0;
      wb_wen_reg       <= 1'b0;
      div_zero_err_reg <= 1'b0;
      zero_reg         <= 1'b0;
    end else begin
      md_start_reg     <= 1'b0;
      wb_wen_reg       <= 1'b0;
      div_zero_err_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            state_reg    <= S_RUN;
            md_start_reg <= 1'b1;
            md_sel_reg   <= md_sel_next;
            zero_reg     <= is_div & bus.divisor_zero;
          end
        end
        S_RUN: begin
          if (cnt_is_one) begin
            state_reg        <= S_WB;
            wb_wen_reg       <= ~zero_reg;
            div_zero_err_reg <= zero_reg;
          end
        end
        S_WB:    state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // mthi/mtlo write straight through only when no mult/div outranks them.
  assign mt_ok = is_idle & ~any_md;

  assign bus.hi_wen   = wb_wen_reg | (mt_ok & bus.op_mthi);
  assign bus.lo_wen   = wb_wen_reg | (mt_ok & ~bus.op_mthi & bus.op_mtlo);
  assign bus.hilo_src = mt_ok & (bus.op_mthi | bus.op_mtlo);

  always_comb begin
    bus.rd_sel = RD_CP0;
    if (bus.op_mfhi)      bus.rd_sel = RD_HI;
    else if (bus.op_mflo) bus.rd_sel = RD_LO;
  end

  assign bus.stall        = ~is_idle & any_op;
  assign bus.busy         = ~is_idle;
  assign bus.md_start     = md_start_reg;
  assign bus.md_sel       = md_sel_reg;
  assign bus.div_zero_err = div_zero_err_reg;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed scenarios plus random
// strobes checked against a schedule-based reference model.
module tb_hilo_muldiv_ctrl;

  localparam int MUL_LAT = 1;
  localparam int DIV_LAT = 34;

  localparam logic [7:0] OP_MULT  = 8'h80;
  localparam logic [7:0] OP_DIV   = 8'h20;
  localparam logic [7:0] OP_DIVU  = 8'h10;
  localparam logic [7:0] OP_MTHI  = 8'h08;
  localparam logic [7:0] OP_MFLO  = 8'h01;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilo_muldiv_ctrl_if bus();

  hilo_muldiv_ctrl #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: one outstanding op, described by its accept cycle and latency.
  bit         m_active;
  bit         m_zero;
  int         m_acc;
  int         m_lat;
  logic [1:0] m_sel;

  logic       e_busy, e_start, e_hi, e_lo, e_src, e_err, e_stall;
  logic [1:0] e_rd, e_sel;

  task automatic set_ops(input logic [7:0] v, input logic dz);
    {bus.op_mult, bus.op_multu, bus.op_div, bus.op_divu,
     bus.op_mthi, bus.op_mtlo, bus.op_mfhi, bus.op_mflo} = v;
    bus.divisor_zero = dz;
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_zero   = 1'b0;
    m_acc    = 0;
    m_lat    = 0;
    m_sel    = 2'b00;
  endtask

  task automatic model_eval();
    logic any_md, mt_ok, wb;
    any_md  = bus.op_mult | bus.op_multu | bus.op_div | bus.op_divu;
    e_busy  = m_active && (cyc > m_acc);
    e_start = m_active && (cyc == m_acc + 1);
    wb      = m_active && (cyc == m_acc + 1 + m_lat);
    mt_ok   = !e_busy && !any_md;
    e_hi    = (wb && !m_zero) || (mt_ok && bus.op_mthi);
    e_lo    = (wb && !m_zero) || (mt_ok && !bus.op_mthi && bus.op_mtlo);
    e_src   = mt_ok && (bus.op_mthi || bus.op_mtlo);
    e_err   = wb && m_zero;
    e_stall = e_busy && (any_md || bus.op_mthi || bus.op_mtlo || bus.op_mfhi || bus.op_mflo);
    e_rd    = bus.op_mfhi ? 2'd1 : (bus.op_mflo ? 2'd2 : 2'd0);
    e_sel   = m_sel;
  endtask

  task automatic model_update();
    bit busy_now, any_md, is_div;
    busy_now = m_active && (cyc > m_acc);
    any_md   = bus.op_mult | bus.op_multu | bus.op_div | bus.op_divu;
    is_div   = bus.op_div | bus.op_divu;
    if (m_active && cyc == m_acc + 1 + m_lat) m_active = 1'b0;
    if (!busy_now && any_md) begin
      m_active = 1'b1;
      m_acc    = cyc;
      m_lat    = is_div ? DIV_LAT : MUL_LAT;
      m_zero   = is_div && bus.divisor_zero;
      m_sel    = bus.op_div ? 2'b10 : bus.op_divu ? 2'b11 : bus.op_mult ? 2'b00 : 2'b01;
      $display("op accept cyc=%0d sel=%0d zero=%0b", cyc, m_sel, m_zero);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    if (rst) model_update();
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_ops(8'h00, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.md_start, bus.md_sel, bus.hi_wen, bus.lo_wen, bus.hilo_src,
         bus.rd_sel, bus.stall, bus.div_zero_err} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0", {bus.md_start, bus.md_sel, bus.hi_wen,
               bus.lo_wen, bus.hilo_src, bus.rd_sel, bus.stall, bus.div_zero_err});
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
    tick();
  endtask

  task automatic test_mult();
    set_ops(OP_MULT, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.md_start !== 1'b0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL mult_T start=%b stall=%b exp 0/0", bus.md_start, bus.stall);
    end
    tick();
    set_ops(8'h00, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.md_start !== 1'b1 || bus.md_sel !== 2'b00 || bus.hi_wen !== 1'b0) begin
      errors++;
      $display("FAIL mult_T1 start=%b sel=%b hi=%b exp 1/00/0", bus.md_start, bus.md_sel, bus.hi_wen);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.hi_wen !== 1'b1 || bus.lo_wen !== 1'b1 || bus.hilo_src !== 1'b0 || bus.md_start !== 1'b0) begin
      errors++;
      $display("FAIL mult_wb hi=%b lo=%b src=%b start=%b exp 1/1/0/0",
               bus.hi_wen, bus.lo_wen, bus.hilo_src, bus.md_start);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.hi_wen !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mult_after hi=%b busy=%b exp 0/0", bus.hi_wen, bus.busy);
    end
    tick();
  endtask

  task automatic test_divu_mflo();
    set_ops(OP_DIVU, 1'b0);
    tick();
    set_ops(8'h00, 1'b0);
    repeat (4) tick();
    set_ops(OP_MFLO, 1'b0);
    for (int k = 5; k <= 36; k++) begin
      @(negedge clk);
      checks++;
      if (bus.stall !== (k <= 35) || bus.rd_sel !== 2'b10 ||
          bus.hi_wen !== (k == 35) || bus.lo_wen !== (k == 35)) begin
        errors++;
        $display("FAIL divu_mflo T+%0d stall=%b rd=%b hi=%b lo=%b exp %b/10/%b/%b",
                 k, bus.stall, bus.rd_sel, bus.hi_wen, bus.lo_wen, k <= 35, k == 35, k == 35);
      end
      tick();
    end
    set_ops(8'h00, 1'b0);
    tick();
  endtask

  task automatic test_div_zero();
    set_ops(OP_DIV, 1'b1);
    tick();
    set_ops(8'h00, 1'b0);
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      checks++;
      if (bus.hi_wen !== 1'b0 || bus.lo_wen !== 1'b0 || bus.div_zero_err !== (k == 35) ||
          bus.md_sel !== 2'b10) begin
        errors++;
        $display("FAIL div_zero T+%0d hi=%b lo=%b err=%b sel=%b exp 0/0/%b/10",
                 k, bus.hi_wen, bus.lo_wen, bus.div_zero_err, bus.md_sel, k == 35);
      end
      tick();
    end
  endtask

  task automatic test_mthi();
    set_ops(OP_MTHI, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.hi_wen !== 1'b1 || bus.lo_wen !== 1'b0 || bus.hilo_src !== 1'b1 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL mthi_idle hi=%b lo=%b src=%b stall=%b exp 1/0/1/0",
               bus.hi_wen, bus.lo_wen, bus.hilo_src, bus.stall);
    end
    tick();
    set_ops(OP_MULT, 1'b0);
    tick();
    set_ops(OP_MTHI, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b1 || bus.hi_wen !== 1'b0) begin
      errors++;
      $display("FAIL mthi_run stall=%b hi=%b exp 1/0", bus.stall, bus.hi_wen);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b1 || bus.hi_wen !== 1'b1 || bus.hilo_src !== 1'b0) begin
      errors++;
      $display("FAIL mthi_wb stall=%b hi=%b src=%b exp 1/1/0", bus.stall, bus.hi_wen, bus.hilo_src);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0 || bus.hi_wen !== 1'b1 || bus.hilo_src !== 1'b1) begin
      errors++;
      $display("FAIL mthi_release stall=%b hi=%b src=%b exp 0/1/1", bus.stall, bus.hi_wen, bus.hilo_src);
    end
    tick();
    set_ops(8'h00, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_op();
    int bad;
    set_ops(OP_DIV, 1'b0);
    tick();
    set_ops(8'h00, 1'b0);
    repeat (9) tick();
    #1 rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bus.busy !== 1'b0 || bus.md_sel !== 2'b00) begin
      errors++;
      $display("FAIL reset_async busy=%b sel=%b exp 0/00", bus.busy, bus.md_sel);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.hi_wen !== 1'b0 || bus.lo_wen !== 1'b0 || bus.busy !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_no_wb bad_cycles=%0d exp 0", bad);
    end
    set_ops(OP_MULT, 1'b0);
    tick();
    set_ops(8'h00, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.md_start !== 1'b1 || bus.md_sel !== 2'b00) begin
      errors++;
      $display("FAIL reset_new_start start=%b sel=%b exp 1/00", bus.md_start, bus.md_sel);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.hi_wen !== 1'b1 || bus.lo_wen !== 1'b1) begin
      errors++;
      $display("FAIL reset_new_wb hi=%b lo=%b exp 1/1", bus.hi_wen, bus.lo_wen);
    end
    tick();
  endtask

  task automatic test_random();
    bit         last_stall;
    int         r;
    logic [7:0] v;
    logic [10:0] got, exp;
    last_stall = 1'b0;
    for (int i = 0; i < 700; i++) begin
      if (!last_stall) begin
        if (i < 600) begin
          r = $urandom_range(0, 15);
          if (r < 6)       v = 8'h00;
          else if (r < 13) v = 8'h01 << $urandom_range(0, 7);
          else             v = 8'($urandom);
          set_ops(v, 1'($urandom_range(0, 1)));
        end else begin
          set_ops(8'h00, 1'b0);
        end
      end
      model_eval();
      @(negedge clk);
      got = {bus.busy, bus.md_start, bus.hi_wen, bus.lo_wen, bus.hilo_src,
             bus.div_zero_err, bus.stall, bus.rd_sel, bus.md_sel};
      exp = {e_busy, e_start, e_hi, e_lo, e_src, e_err, e_stall, e_rd, e_sel};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b exp=%b (busy,start,hi,lo,src,err,stall,rd,sel)",
                 cyc, got, exp);
      end
      last_stall = e_stall;
      tick();
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL random_drain busy=%b exp 0", bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu_mflo();
    test_div_zero();
    test_mthi();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
